// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: WIDTH cycles from the accepted start edge to done; one operation per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, so requests made while busy or in DONE are dropped.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             v
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;

   logic             x;
   logic             y;
   logic             d_bit;
   logic             borrow_nxt;

   // Full-subtractor cell on the current LSB pair.
   always_comb begin
      x          = a_sh[0];
      y          = b_sh[0];
      d_bit      = x ^ y ^ borrow;
      borrow_nxt = (~x & y) | (~x & borrow) | (y & borrow);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         v      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  borrow <= bin;
                  cnt    <= '0;
                  a_msb  <= a[WIDTH-1];
                  b_msb  <= b[WIDTH-1];
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               diff   <= {d_bit, diff[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               borrow <= borrow_nxt;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // d_bit is the result MSB on this final bit-cycle.
                  bout  <= borrow_nxt;
                  v     <= (a_msb != b_msb) & (d_bit != a_msb);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
